fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//   Parametrised single-clock FIFO; successor to the fixed 4x8-bit FIFO.
//   Generic data width and power-of-two depth, occupancy count, programmable
//   almost-full/almost-empty flags, sticky overflow/underflow error flags.
//   Accepts a simultaneous read and write when full. Optional first-word
//   fall-through read mode. Sits between a producer and a consumer in one clock domain.
// PARAMETERS
//   WIDTH      8   data width in bits, >= 1
//   DEPTH      16  number of entries; power of two, >= 2
//   AF_LVL     14  almost_full asserted when count >= AF_LVL, 1..DEPTH
//   AE_LVL     2   almost_empty asserted when count <= AE_LVL, 0..DEPTH-1
//   Derived: AW = $clog2(DEPTH), CW = AW+1.
// PORTS
//   clk          in   1      clock; all state changes on the rising edge
//   rst          in   1      asynchronous, active-high reset
//   write        in   1      write request, sampled at rising clk
//   wdata        in   WIDTH  write data
//   read         in   1      read (pop) request, sampled at rising clk
//   rdata        out  WIDTH  read data (timing depends on mode)
//   empty        out  1      count == 0
//   full         out  1      count == DEPTH
//   almost_empty out  1      count <= AE_LVL
//   almost_full  out  1      count >= AF_LVL
//   count        out  CW     current occupancy, 0..DEPTH
//   overflow     out  1      sticky: a write was dropped
//   underflow    out  1      sticky: a read was dropped
//   clr_err      in   1      synchronous clear of overflow/underflow
//   diag_waddr   out  AW     write pointer
//   diag_raddr   out  AW     read pointer
// BEHAVIOUR
//   - Reset (async, while rst=1): waddr=raddr=0, count=0, rdata=0,
//     overflow=underflow=0. empty=1, full=0, almost_empty=1, almost_full=0.
//     Memory array is not reset. Reset mid-transfer discards all contents.
//   - rd_ok = read & ~empty. wr_ok = write & (~full | rd_ok).
//   - wr_ok: mem[waddr] <= wdata; waddr <= waddr+1 (wraps DEPTH-1 -> 0).
//   - rd_ok: raddr <= raddr+1 (wraps DEPTH-1 -> 0).
//   - count <= count + wr_ok - rd_ok. Both ok: count unchanged.
//   - Full + read + write: both accepted; count stays DEPTH, no overflow.
//   - Empty + read + write: write accepted, read dropped, underflow set;
//     count becomes 1.
//   - Dropped write (write & ~wr_ok) sets overflow; memory/pointers unchanged.
//   - Dropped read (read & empty) sets underflow; rdata unchanged.
//   - clr_err clears both sticky flags next edge; a new error event in the
//     same cycle wins (flag stays 1).
//   - All flags are combinational decodes of registered count; glitch-free
//     w.r.t. clk. count and flags reflect an operation one edge after it.
//   - No internal state machine beyond pointer/count registers; occupancy is
//     fully defined by count (no waddr==raddr ambiguity).
// CONFIGURATION
//   FIFO_FWFT_EN undefined (standard mode):
//     - rd_ok loads rdata <= mem[raddr] at the same edge; data valid the
//       cycle after read is sampled (1-cycle latency). rdata holds otherwise.
//   FIFO_FWFT_EN defined (first-word fall-through):
//     - rdata = mem[raddr] when ~empty, else 0 (combinational).
//     - Head word visible the cycle after it is written into an empty FIFO;
//       read pops it, next word appears after that edge.
//   All other behaviour identical in both modes.
// TESTING (WIDTH=8, DEPTH=16, AF_LVL=14, AE_LVL=2; run in both modes)
//   1. Reset: rst=1 10ns -> empty=1 full=0 count=0 rdata=0 flags 0, ptrs 0.
//   2. Write 0x01..0x10 -> count=16 full=1 almost_full at count 14;
//      read 16 -> data 0x01..0x10 in order, empty=1, pointers wrap to 0.
//   3. Full, write 0x55 alone -> overflow=1, count=16, data intact;
//      clr_err=1 -> overflow=0.
//   4. Full, read+write 0xAA same cycle -> count=16, overflow=0; 16 reads
//      later 0xAA is the last word returned.
//   5. Empty, read+write 0x33 -> underflow=1, count=1; next read -> 0x33.
//   6. Write 5 words, assert rst mid-burst -> count=0 empty=1 immediately
//      (async), subsequent write/read of 0x77 returns 0x77.

Source files
------------

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO.
// Occupancy is tracked by an explicit count register, so full/empty never
// depend on comparing pointers. Almost-full/almost-empty levels are
// programmable, and dropped writes/reads are recorded in sticky error flags.
// Read mode is selected by the macro FIFO_FWFT_EN:
//   undefined : standard mode, rdata registered one cycle after a read
//   defined   : first-word fall-through, head word shown combinationally
// Valid/ready contract: a write is taken on a rising edge when write=1 and
// the FIFO is not full (or a read is taken on the same edge); a read is
// taken when read=1 and the FIFO is not empty. Requests that cannot be
// taken are dropped and flagged, never stalled.
module fifo_sync_param #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  parameter  int AF_LVL = 14,
  parameter  int AE_LVL = 2,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic [WIDTH-1:0] wdata,
  input  logic             read,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err,
  output logic [AW-1:0]    diag_waddr,
  output logic [AW-1:0]    diag_raddr
);

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LVL);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LVL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_waddr;
  logic [AW-1:0]    r_raddr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_empty;
  logic w_full;
  logic w_rd_ok;
  logic w_wr_ok;
  logic w_wr_drop;
  logic w_rd_drop;

  // Status decodes come straight from the registered count, so they only
  // move on clock edges.
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_DEPTH);
  // A read frees a slot on the same edge, so a full FIFO still takes a write
  // when it is being read at the same time.
  assign w_rd_ok   = read & ~w_empty;
  assign w_wr_ok   = write & (~w_full | w_rd_ok);
  assign w_wr_drop = write & ~w_wr_ok;
  assign w_rd_drop = read & w_empty;

  // Storage array; deliberately not reset, contents are qualified by count.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_waddr] <= wdata;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**AW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waddr <= '0;
      r_raddr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) r_waddr <= r_waddr + AW'(1);
      if (w_rd_ok) r_raddr <= r_raddr + AW'(1);
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_drop)    r_overflow <= 1'b1;
      else if (clr_err) r_overflow <= 1'b0;
      if (w_rd_drop)    r_underflow <= 1'b1;
      else if (clr_err) r_underflow <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  // Fall-through: the head entry is always presented, zero when empty.
  assign rdata = w_empty ? '0 : r_mem[r_raddr];
`else
  logic [WIDTH-1:0] r_rdata;

  // Standard mode: the popped word is registered and held until the next pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_rdata <= '0;
    else if (w_rd_ok) r_rdata <= r_mem[r_raddr];
  end

  assign rdata = r_rdata;
`endif

  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_count <= C_AE);
  assign almost_full  = (r_count >= C_AF);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign diag_waddr   = r_waddr;
  assign diag_raddr   = r_raddr;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: self-checking bench for fifo_sync_param
// (WIDTH=8, DEPTH=16, AF_LVL=14, AE_LVL=2). Builds in either read mode;
// define FIFO_FWFT_EN for the fall-through variant.
module tb_fifo_sync_param;

  localparam int W = 8;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         write = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         read = 1'b0;
  logic         clr_err = 1'b0;
  logic [W-1:0] rdata;
  logic         empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0]   count;
  logic [3:0]   diag_waddr, diag_raddr;

  always #5 clk = ~clk;

  fifo_sync_param #(.WIDTH(8), .DEPTH(16), .AF_LVL(14), .AE_LVL(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .write        (write),
    .wdata        (wdata),
    .read         (read),
    .rdata        (rdata),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err),
    .diag_waddr   (diag_waddr),
    .diag_raddr   (diag_raddr)
  );

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_rdata;
  logic [W-1:0] m_last;
  logic [3:0]   m_wa, m_ra;
  bit           m_ovf, m_unf;
  int           total = 0;
  int           bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rdata = '0;
    m_wa    = '0;
    m_ra    = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic check_state();
    int n;
    int exp_rd;
    n = exp_q.size();
`ifdef FIFO_FWFT_EN
    exp_rd = (n == 0) ? 0 : int'(exp_q[0]);
`else
    exp_rd = int'(m_rdata);
`endif
    check("count",        int'(count),        n);
    check("empty",        int'(empty),        int'(n == 0));
    check("full",         int'(full),         int'(n == 16));
    check("almost_empty", int'(almost_empty), int'(n <= 2));
    check("almost_full",  int'(almost_full),  int'(n >= 14));
    check("overflow",     int'(overflow),     int'(m_ovf));
    check("underflow",    int'(underflow),    int'(m_unf));
    check("diag_waddr",   int'(diag_waddr),   int'(m_wa));
    check("diag_raddr",   int'(diag_raddr),   int'(m_ra));
    check("rdata",        int'(rdata),        exp_rd);
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge; drives one cycle and checks afterwards.
  task automatic step(input bit wr, input logic [W-1:0] wd, input bit rd, input bit clr);
    bit           rd_ok, wr_ok;
    logic [W-1:0] pop_d;
    rd_ok   = rd && (exp_q.size() != 0);
    wr_ok   = wr && ((exp_q.size() < 16) || rd_ok);
    pop_d   = '0;
    write   = wr;
    wdata   = wd;
    read    = rd;
    clr_err = clr;
    if (rd_ok) begin
      pop_d = exp_q.pop_front();
      m_last = pop_d;
    end
`ifdef FIFO_FWFT_EN
    if (rd_ok) check("fwft_head", int'(rdata), int'(pop_d));
`endif
    @(posedge clk);
    #1;
    write   = 1'b0;
    read    = 1'b0;
    clr_err = 1'b0;
    if (rd_ok) begin
      m_ra++;
      m_rdata = pop_d;
    end
    if (wr_ok) begin
      exp_q.push_back(wd);
      m_wa++;
    end
    if (wr && !wr_ok) m_ovf = 1'b1;
    else if (clr)     m_ovf = 1'b0;
    if (rd && !rd_ok) m_unf = 1'b1;
    else if (clr)     m_unf = 1'b0;
`ifndef FIFO_FWFT_EN
    if (rd_ok) check("read_data", int'(rdata), int'(pop_d));
`endif
    check_state();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit           wr;
    logic [W-1:0] wd;
    bit           rd;
    bit           clr;
    int           cnt;
    bit           ovf;
    bit           unf;
  } vec_t;

  vec_t tbl[10];

  task automatic apply_tbl(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].clr);
      check($sformatf("tbl%0d_count", i), int'(count),     tbl[i].cnt);
      check($sformatf("tbl%0d_ovf", i),   int'(overflow),  int'(tbl[i].ovf));
      check($sformatf("tbl%0d_unf", i),   int'(underflow), int'(tbl[i].unf));
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                wr  wd     rd clr cnt ovf unf
    tbl[0] = '{1'b1, 8'h55, 1'b0, 1'b0, 16, 1'b1, 1'b0}; // full, lone write dropped
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 16, 1'b0, 1'b0}; // clear
    tbl[2] = '{1'b1, 8'hAA, 1'b1, 1'b0, 16, 1'b0, 1'b0}; // full, read+write
    tbl[3] = '{1'b1, 8'h33, 1'b1, 1'b0,  1, 1'b0, 1'b1}; // empty, read+write
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0,  0, 1'b0, 1'b1}; // pop 0x33
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1,  0, 1'b0, 1'b1}; // new error beats clear
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1,  0, 1'b0, 1'b0}; // clear
    tbl[7] = '{1'b1, 8'h44, 1'b0, 1'b1,  1, 1'b0, 1'b0}; // write with clear
    tbl[8] = '{1'b1, 8'h45, 1'b1, 1'b0,  1, 1'b0, 1'b0}; // read+write mid-range
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0,  0, 1'b0, 1'b0}; // drain

    // 1. reset
    model_reset();
    rst = 1'b1;
    #10;
    check_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_state();

    // 2. fill 0x01..0x10, then drain in order
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, W'(i), 1'b0, 1'b0);
      if (i == 13) check("af_below_lvl", int'(almost_full), 0);
      if (i == 14) check("af_at_lvl",    int'(almost_full), 1);
    end
    check("full_after_16", int'(full), 1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check("drain_order", int'(m_last), i);
    end
    check("empty_after_drain", int'(empty), 1);
    check("waddr_wrapped", int'(diag_waddr), 0);
    check("raddr_wrapped", int'(diag_raddr), 0);

    // 3./4. overflow, clear, full read+write
    for (int i = 0; i < 16; i++) step(1'b1, W'(8'h20 + i), 1'b0, 1'b0);
    apply_tbl(0, 2);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("last_word_aa", int'(m_last), 8'hAA);

    // 5. empty read+write and flag corner cases
    apply_tbl(3, 9);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step(bit'($urandom_range(0, 99) < 55), W'($urandom_range(0, 255)),
           bit'($urandom_range(0, 99) < 45), bit'($urandom_range(0, 19) == 0));
    end
    while (exp_q.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // 6. async reset in the middle of a burst
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'hC0 + i), 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_count", int'(count), 0);
    check("rst_async_empty", int'(empty), 1);
    check_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("post_reset_77", int'(m_last), 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
